timer_device: RTL and testbench

//  Memory-mapped interval timer; responder on the processor's mem-stage IO bus (same bus as KEY/SW/HEX/LEDR).

---
 rtl/timer_device.sv | 103 ++++++++++
 tb/tb_timer_device.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/timer_device.sv
// timer_device: memory-mapped interval timer on the mem-stage IO bus.
//   A prescaler divides clk by CLK_PER_TICK. Each tick advances TCNT, which
//   wraps at TLIM (when TLIM is nonzero). Every wrap sets the sticky READY flag,
//   and a wrap while READY is still set also sets OVERRUN. irq = READY & IE.
// Ports:
//   clk      system clock; all state updates on the rising edge
//   reset    asynchronous, active-high reset
//   addr     bus address
//   wrtEn    store strobe
//   wrtData  store data
//   rdData   load data; combinational from addr, 0 when unselected
//   sel      addr hits TCNT, TLIM or TCTL
//   irq      TCTL.READY & TCTL.IE
module timer_device #(
  parameter int               DBITS        = 32,
  parameter logic [DBITS-1:0] ADDR_TCNT    = 32'hF0000020,
  parameter logic [DBITS-1:0] ADDR_TLIM    = 32'hF0000024,
  parameter logic [DBITS-1:0] ADDR_TCTL    = 32'hF0000120,
  parameter int               CLK_PER_TICK = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wrtEn,
  input  logic [DBITS-1:0] wrtData,
  output logic [DBITS-1:0] rdData,
  output logic             sel,
  output logic             irq
);

  // A prescaler width of at least 1 keeps CLK_PER_TICK=1 legal (tick every cycle).
  localparam int            PW        = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_TICK - 1);

  logic [PW-1:0]    prescaler;
  logic [DBITS-1:0] tcnt, tlim, tctlVal;
  logic             ready, overrun, ie;

  logic selTcnt, selTlim, selTctl;
  logic wrTcnt, wrTlim, wrTctl;
  logic tick, atLimit, wrapSet, clr0, clr2;

  assign selTcnt = (addr == ADDR_TCNT);
  assign selTlim = (addr == ADDR_TLIM);
  assign selTctl = (addr == ADDR_TCTL);
  assign sel     = selTcnt | selTlim | selTctl;

  assign wrTcnt = wrtEn & selTcnt;
  assign wrTlim = wrtEn & selTlim;
  assign wrTctl = wrtEn & selTctl;

  assign tick    = (prescaler == PRESC_MAX);
  // TLIM==0 means free-running, so no limit compare (and no TLIM-1 underflow).
  assign atLimit = (tlim != '0) && (tcnt >= (tlim - DBITS'(1)));
  // A TCNT/TLIM write replaces the counter, so it suppresses the wrap event.
  assign wrapSet = tick & atLimit & ~wrTcnt & ~wrTlim;

  // Flags are cleared by writing 0 to their bit; writing 1 leaves them alone.
  assign clr0 = wrTctl & ~wrtData[0];
  assign clr2 = wrTctl & ~wrtData[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      tcnt      <= '0;
      tlim      <= '0;
      ready     <= 1'b0;
      overrun   <= 1'b0;
      ie        <= 1'b0;
    end else begin
      if (wrTcnt || wrTlim || tick) prescaler <= '0;
      else                          prescaler <= prescaler + PW'(1);

      if (wrTlim)      tcnt <= '0;
      else if (wrTcnt) tcnt <= wrtData;
      else if (tick)   tcnt <= atLimit ? '0 : tcnt + DBITS'(1);

      if (wrTlim) tlim <= wrtData;

      // A wrap coinciding with a READY clear re-arms READY without overrun.
      ready   <= wrapSet | (ready & ~clr0);
      overrun <= (wrapSet & ready & ~clr0) | (overrun & ~clr2);
      if (wrTctl) ie <= wrtData[8];
    end
  end

  always_comb begin
    tctlVal    = '0;
    tctlVal[0] = ready;
    tctlVal[2] = overrun;
    tctlVal[8] = ie;
  end

  always_comb begin
    rdData = '0;
    if (selTcnt)      rdData = tcnt;
    else if (selTlim) rdData = tlim;
    else if (selTctl) rdData = tctlVal;
  end

  assign irq = ready & ie;

endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device with CLK_PER_TICK=4. Inputs change on the
// falling edge; combinational reads are sampled shortly after it.
module tb_timer_device;

  localparam logic [31:0] A_TCNT = 32'hF0000020;
  localparam logic [31:0] A_TLIM = 32'hF0000024;
  localparam logic [31:0] A_TCTL = 32'hF0000120;
  localparam logic [31:0] A_NONE = 32'hF0000028;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wrtData, rdData;
  logic        wrtEn, sel, irq;

  int nCmp = 0;
  int nBad = 0;

  timer_device #(.DBITS(32), .ADDR_TCNT(A_TCNT), .ADDR_TLIM(A_TLIM),
                 .ADDR_TCTL(A_TCTL), .CLK_PER_TICK(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wrtEn(wrtEn),
    .wrtData(wrtData), .rdData(rdData), .sel(sel), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        doWr;
    logic [31:0] wa;
    logic [31:0] wd;
    int          idle;
    logic [31:0] ra;
    logic [31:0] expRd;
    logic        expSel;
    logic        expIrq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called on a falling edge; the write lands on the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wrtData = d; wrtEn = 1'b1;
    @(negedge clk);
    wrtEn = 1'b0; wrtData = '0; addr = A_NONE;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rdChk(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rdData, exp);
  endtask

  function automatic vec_t mk(input logic doWr, input logic [31:0] wa, input logic [31:0] wd,
                              input int idl, input logic [31:0] ra, input logic [31:0] expRd,
                              input logic expSel, input logic expIrq);
    vec_t v;
    v.doWr = doWr; v.wa = wa; v.wd = wd; v.idle = idl;
    v.ra = ra; v.expRd = expRd; v.expSel = expSel; v.expIrq = expIrq;
    return v;
  endfunction

  initial begin
    reset = 1'b1; addr = A_NONE; wrtEn = 1'b0; wrtData = '0;

    // Reset readback, then TLIM=3 with IE: wraps every 12 cycles.
    vecs.push_back(mk(0, A_NONE, 0,      0, A_TCNT, 32'h0,   1, 0));
    vecs.push_back(mk(0, A_NONE, 0,      0, A_TLIM, 32'h0,   1, 0));
    vecs.push_back(mk(0, A_NONE, 0,      0, A_TCTL, 32'h0,   1, 0));
    vecs.push_back(mk(0, A_NONE, 0,      0, A_NONE, 32'h0,   0, 0));
    vecs.push_back(mk(1, A_TCTL, 32'h100,0, A_TCTL, 32'h100, 1, 0));
    vecs.push_back(mk(1, A_TLIM, 32'h3,  0, A_TCNT, 32'h0,   1, 0));
    vecs.push_back(mk(0, A_NONE, 0,      0, A_TLIM, 32'h3,   1, 0));
    vecs.push_back(mk(0, A_NONE, 0,      4, A_TCNT, 32'h1,   1, 0));
    vecs.push_back(mk(0, A_NONE, 0,      4, A_TCNT, 32'h2,   1, 0));
    vecs.push_back(mk(0, A_NONE, 0,      4, A_TCNT, 32'h0,   1, 1));
    vecs.push_back(mk(0, A_NONE, 0,      0, A_TCTL, 32'h101, 1, 1));
    // Unmapped store of 0 must not clear READY.
    vecs.push_back(mk(1, A_NONE, 32'h0,  0, A_TCTL, 32'h101, 1, 1));
    vecs.push_back(mk(0, A_NONE, 0,      7, A_TCNT, 32'h2,   1, 1));
    // Second wrap with READY still set -> OVERRUN.
    vecs.push_back(mk(0, A_NONE, 0,      4, A_TCTL, 32'h105, 1, 1));
    vecs.push_back(mk(1, A_TCTL, 32'h100,0, A_TCTL, 32'h100, 1, 0));

    idle(2);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].doWr) wr(vecs[i].wa, vecs[i].wd);
      idle(vecs[i].idle);
      addr = vecs[i].ra;
      #1;
      check($sformatf("vec%0d.rdData", i), rdData, vecs[i].expRd);
      check($sformatf("vec%0d.sel", i), {31'b0, sel}, {31'b0, vecs[i].expSel});
      check($sformatf("vec%0d.irq", i), {31'b0, irq}, {31'b0, vecs[i].expIrq});
    end

    // READY clear in the same cycle as a wrap: READY stays, no overrun.
    wr(A_TLIM, 32'h3);
    idle(12);
    rdChk("wrapClr.pre", A_TCTL, 32'h101);
    idle(11);
    wr(A_TCTL, 32'h100);
    rdChk("wrapClr.tctl", A_TCTL, 32'h101);
    rdChk("wrapClr.tcnt", A_TCNT, 32'h0);
    check("wrapClr.irq", {31'b0, irq}, 32'h1);

    // Free-running rollover at TLIM=0 sets no flag.
    wr(A_TLIM, 32'h0);
    wr(A_TCNT, 32'hFFFF_FFFF);
    rdChk("roll.wr", A_TCNT, 32'hFFFF_FFFF);
    idle(3);
    rdChk("roll.hold", A_TCNT, 32'hFFFF_FFFF);
    idle(1);
    rdChk("roll.zero", A_TCNT, 32'h0);
    rdChk("roll.tctl", A_TCTL, 32'h101);
    // Store to TCNT in a tick cycle wins over the increment.
    idle(3);
    wr(A_TCNT, 32'h55);
    rdChk("tickWr.val", A_TCNT, 32'h55);
    idle(3);
    rdChk("tickWr.hold", A_TCNT, 32'h55);
    idle(1);
    rdChk("tickWr.inc", A_TCNT, 32'h56);

    // Asynchronous reset mid-count (TCNT=2, prescaler=2).
    wr(A_TCNT, 32'h2);
    idle(2);
    rdChk("rst.preCnt", A_TCNT, 32'h2);
    check("rst.preIrq", {31'b0, irq}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    rdChk("rst.tcnt", A_TCNT, 32'h0);
    rdChk("rst.tlim", A_TLIM, 32'h0);
    rdChk("rst.tctl", A_TCTL, 32'h0);
    check("rst.irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    rdChk("rst.resume3", A_TCNT, 32'h0);
    idle(1);
    rdChk("rst.resume4", A_TCNT, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
